// File: rtl/rv_defs.sv
// Shared encodings for the memory arbiter: FSM states, bus owner and the
// default starvation limit.
package rv_defs;

    localparam int unsigned ARB_STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_OWN_I = 1'b0,
        ARB_OWN_D = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/rv_arb_starve_cnt.sv
// Saturating count of data grants taken while a fetch waits; force_fetch_o
// tells the arbiter the fetch must win the next arbitration.
module rv_arb_starve_cnt
    import rv_defs::*;
#(
    parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic force_fetch_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign force_fetch_o = (cnt_q == LIMIT);

endmodule

// File: rtl/rv_mem_arbiter.sv
// Shares one single-port memory bus between the fetch and data ports of the
// core. Data wins by default; the starvation counter guarantees fetch progress.
//
// state    | meaning
// ARB_IDLE | no transaction; arbitrate and latch the winner's request
// ARB_REQ  | mem_req_o held with stable address/data until mem_gnt_i
// ARB_WAIT | granted; waiting for mem_rvalid_i to produce the done pulse
module rv_mem_arbiter
    import rv_defs::*;
#(
    parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] im_addr_i,
    input  logic        im_rd_i,
    input  logic        im_kill_i,
    output logic [31:0] im_data_o,
    output logic        im_valid_o,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_load_i,
    input  logic        dm_store_i,
    output logic        dm_ready_o,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    output logic        mem_we_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    arb_state_e state_q, state_d;
    arb_owner_e owner_q, owner_d;
    logic       kill_q, kill_d;
    logic       req_d, we_d, im_valid_d, load_done_d, store_done_d, ready_d;
    logic [31:0] addr_d, wdata_d, im_data_d, load_data_d;
    logic [3:0] be_d;
    logic       starve_inc, starve_clr, force_fetch;
    logic       dm_req;

    assign dm_req = dm_load_i | dm_store_i;

    rv_arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clr_i         (starve_clr),
        .inc_i         (starve_inc),
        .force_fetch_o (force_fetch)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        kill_d       = kill_q;
        req_d        = mem_req_o;
        addr_d       = mem_addr_o;
        wdata_d      = mem_wdata_o;
        be_d         = mem_be_o;
        we_d         = mem_we_o;
        im_valid_d   = 1'b0;
        im_data_d    = im_data_o;
        load_done_d  = 1'b0;
        store_done_d = 1'b0;
        load_data_d  = dm_data_l_o;
        starve_inc   = 1'b0;
        starve_clr   = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                kill_d     = 1'b0;
                starve_clr = !im_rd_i;
                if (im_rd_i && (force_fetch || !dm_req)) begin
                    owner_d    = ARB_OWN_I;
                    addr_d     = im_addr_i & ~32'h3;
                    wdata_d    = '0;
                    be_d       = 4'hF;
                    we_d       = 1'b0;
                    req_d      = 1'b1;
                    starve_clr = 1'b1;
                    state_d    = ARB_REQ;
                end else if (dm_req) begin
                    // a store wins over a simultaneous (illegal) load
                    owner_d    = ARB_OWN_D;
                    addr_d     = dm_addr_i & ~32'h3;
                    wdata_d    = dm_data_s_i;
                    be_d       = dm_store_i ? dm_data_select_i : 4'hF;
                    we_d       = dm_store_i;
                    req_d      = 1'b1;
                    starve_inc = im_rd_i;
                    state_d    = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if ((owner_q == ARB_OWN_I) && im_kill_i) kill_d = 1'b1;
                if (mem_gnt_i) begin
                    req_d   = 1'b0;
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if ((owner_q == ARB_OWN_I) && im_kill_i) kill_d = 1'b1;
                if (mem_rvalid_i) begin
                    state_d = ARB_IDLE;
                    kill_d  = 1'b0;
                    if (owner_q == ARB_OWN_I) begin
                        if (!kill_q && !im_kill_i) begin
                            im_valid_d = 1'b1;
                            im_data_d  = mem_rdata_i;
                        end
                    end else if (mem_we_o) begin
                        store_done_d = 1'b1;
                    end else begin
                        load_done_d = 1'b1;
                        load_data_d = mem_rdata_i;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        ready_d = (state_d == ARB_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= ARB_IDLE;
            owner_q         <= ARB_OWN_I;
            kill_q          <= 1'b0;
            mem_req_o       <= 1'b0;
            mem_addr_o      <= '0;
            mem_wdata_o     <= '0;
            mem_be_o        <= '0;
            mem_we_o        <= 1'b0;
            im_valid_o      <= 1'b0;
            im_data_o       <= '0;
            dm_load_done_o  <= 1'b0;
            dm_store_done_o <= 1'b0;
            dm_data_l_o     <= '0;
            dm_ready_o      <= 1'b1;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            kill_q          <= kill_d;
            mem_req_o       <= req_d;
            mem_addr_o      <= addr_d;
            mem_wdata_o     <= wdata_d;
            mem_be_o        <= be_d;
            mem_we_o        <= we_d;
            im_valid_o      <= im_valid_d;
            im_data_o       <= im_data_d;
            dm_load_done_o  <= load_done_d;
            dm_store_done_o <= store_done_d;
            dm_data_l_o     <= load_data_d;
            dm_ready_o      <= ready_d;
        end
    end

endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
- Shares one single-port memory bus between the CPU instruction-fetch port (im_*) and data port (dm_*).
- Sits between rv_cpu and the memory/bus bridge.
- Data accesses get priority so pipeline stalls stay short. A starvation counter guarantees fetch progress.
- Supports fetch kill on branch: a killed fetch's response is discarded, never forwarded.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch is pending before fetch is forced next. Legal range 1..15.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- im_addr_i  in  32  fetch address
- im_rd_i  in  1  fetch request level; held until im_valid_o or im_kill_i
- im_kill_i  in  1  abandon current fetch (branch taken)
- im_data_o  out  32  fetched instruction
- im_valid_o  out  1  one-cycle pulse, im_data_o valid
- dm_addr_i  in  32  data address
- dm_data_s_i  in  32  store data
- dm_data_select_i  in  4  byte enables
- dm_load_i  in  1  load request level
- dm_store_i  in  1  store request level
- dm_ready_o  out  1  arbiter idle, can accept a data request this cycle
- dm_data_l_o  out  32  load data
- dm_load_done_o  out  1  one-cycle pulse
- dm_store_done_o  out  1  one-cycle pulse
- mem_addr_o  out  32  bus address, word aligned ([1:0] forced 0)
- mem_wdata_o  out  32  bus write data
- mem_be_o  out  4  byte enables; 4'hF for reads
- mem_we_o  out  1  write strobe, qualified by mem_req_o
- mem_req_o  out  1  bus request, held until mem_gnt_i
- mem_gnt_i  in  1  bus accepted request this cycle
- mem_rvalid_i  in  1  read data / write ack; exactly one per granted request
- mem_rdata_i  in  32  read data

Behaviour:
- All outputs are registered.
- Reset values: all strobes 0, dm_ready_o = 1, data/address outputs 0, FSM in IDLE, starve counter 0, kill flag 0.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - Selects a requester; priority is data over fetch.
  - If a fetch is pending and starve_cnt == STARVE_LIMIT, fetch wins.
  - Latches address, data, BE and WE for the winner, sets owner, asserts mem_req_o next cycle, and goes to REQ.
- REQ:
  - mem_req_o stays high with stable outputs until mem_gnt_i, then the FSM goes to WAIT.
  - mem_req_o drops in the cycle after the grant.
- WAIT:
  - On mem_rvalid_i, pulse the owner's done/valid output in the next cycle with data registered from mem_rdata_i, then return to IDLE.
- Minimum latency: request seen in IDLE at cycle 0, mem_req_o at cycle 1, grant at cycle 1 gives rvalid at cycle 2 at the earliest, so the done pulse arrives at cycle 3.
- Back-to-back: the FSM takes one IDLE cycle between transactions. dm_ready_o is high only in IDLE.
- Starve counter:
  - Increments when data wins while im_rd_i is high.
  - Clears on any fetch grant or when im_rd_i is low in IDLE.
  - Saturates at STARVE_LIMIT.
- Simultaneous dm_load_i and dm_store_i: the store is serviced and the load is ignored. The requester must not do this.
- im_kill_i:
  - In IDLE: ignored.
  - In REQ or WAIT with fetch owner: sets kill_flag. The transaction still completes on the bus (no request withdrawal), but im_valid_o is suppressed.
  - kill_flag clears on return to IDLE.
  - A kill arriving in the same cycle as mem_rvalid_i also suppresses im_valid_o.
- A requester that drops its request after its grant is not aborted; the done pulse is still produced.
- mem_rvalid_i in IDLE or REQ is a protocol error and is ignored.
- Reset mid-transaction: the FSM goes to IDLE immediately and mem_req_o drops asynchronously. No done pulse is produced for the aborted transaction.

Decomposition:
- Shared package rv_defs gets:
  - FSM state encodings (ARB_IDLE, ARB_REQ, ARB_WAIT)
  - owner encodings (ARB_OWN_I, ARB_OWN_D)
  - the default STARVE_LIMIT constant
- One natural sub-module: rv_arb_starve_cnt, the saturating starvation counter with clear/increment/force-fetch output.

Test Plan:
- Single fetch, im_addr_i = 0x100, gnt at cycle 1, rvalid at cycle 2 with 0x00000013 -> mem_addr_o = 0x100, mem_we_o = 0, im_valid_o pulse at cycle 3 with im_data_o = 0x00000013.
- Store to 0x2002, dm_data_select_i = 4'b1100, data 0xAABB0000 -> mem_addr_o = 0x2000, mem_be_o = 4'b1100, mem_we_o = 1, dm_store_done_o one pulse, dm_ready_o low from request until return to IDLE.
- Fetch and load both requesting in IDLE -> load granted first, fetch granted in the following transaction. Continuous loads with fetch held and STARVE_LIMIT = 4 -> exactly 4 data grants, then 1 fetch grant.
- im_kill_i pulsed during WAIT of fetch to 0x40 -> bus transaction completes, no im_valid_o. A new fetch to 0x80 afterwards returns normally.
- mem_gnt_i held low for 10 cycles -> mem_req_o, mem_addr_o and mem_be_o stay stable all 10 cycles, with no done pulses.
- rst_i asserted in WAIT, then rvalid arrives after reset is released -> no done pulse, FSM in IDLE, all outputs at reset values.
